// File: rtl/mem_access_unit_if.sv
// Wishbone-classic data bus between the memory access unit (master) and a responder (slave).
interface mem_access_unit_if;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_dat_o;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o;
  logic        dbus_cyc_o;
  logic        dbus_stb_o;
  logic [31:0] dbus_dat_i;
  logic        dbus_ack_i;
  logic        dbus_err_i;

  modport master (
    output dbus_addr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o, dbus_stb_o,
    input  dbus_dat_i, dbus_ack_i, dbus_err_i
  );

  modport slave (
    input  dbus_addr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o, dbus_stb_o,
    output dbus_dat_i, dbus_ack_i, dbus_err_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one Wishbone-classic access per request, stalling the
// pipeline while the bus cycle is outstanding, with byte/halfword lane steering.
module mem_access_unit (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic              mem_flush_i,
  output logic              mem_stall_req_o,
  output logic [31:0]       rdata_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  mem_access_unit_if.master dbus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } req_t;

  state_e                         state_q;
  req_t                           req_q;
  logic                           kill_q, cyc_q, we_q, mis_q, err_q;
  logic [31:0]                    addr_q, rdata_q, ext;
  logic [NUM_LANES-1:0]           sel_q, sel_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] dat_q, dat_d, rlane;
  logic                           aligned;
  logic [7:0]                     lb;
  logic [15:0]                    lh;

  always_comb begin
    case (req_size_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr_i[0];
      2'b10:   aligned = (req_addr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Per-lane store steering: byte/halfword data is replicated so the selected lanes carry it.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LIDX = 2'(l);
    assign sel_d[l] = (req_size_i == 2'b00) ? (req_addr_i[1:0] == LIDX) :
                      (req_size_i == 2'b01) ? (req_addr_i[1] == LIDX[1]) : 1'b1;
    assign dat_d[l] = (req_size_i == 2'b00) ? req_wdata_i[VEC_W-1:0] :
                      (req_size_i == 2'b01) ? req_wdata_i[VEC_W*(l%2) +: VEC_W] :
                                              req_wdata_i[VEC_W*l +: VEC_W];
  end

  assign rlane = dbus.dbus_dat_i;

  always_comb begin
    lb = rlane[req_q.off];
    lh = req_q.off[1] ? dbus.dbus_dat_i[31:16] : dbus.dbus_dat_i[15:0];
    case (req_q.size)
      2'b00:   ext = {{24{~req_q.uns & lb[7]}}, lb};
      2'b01:   ext = {{16{~req_q.uns & lh[15]}}, lh};
      default: ext = dbus.dbus_dat_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      kill_q  <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && !mem_flush_i) begin
            if (aligned) begin
              cyc_q   <= 1'b1;
              we_q    <= req_we_i;
              addr_q  <= {req_addr_i[31:2], 2'b00};
              sel_q   <= sel_d;
              dat_q   <= dat_d;
              req_q   <= '{we: req_we_i, size: req_size_i, uns: req_unsigned_i,
                           off: req_addr_i[1:0]};
              kill_q  <= 1'b0;
              state_q <= BUSY;
            end else begin
              mis_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dbus.dbus_ack_i || dbus.dbus_err_i) begin
            cyc_q <= 1'b0;
            // A killed access still completes on the bus but leaves no architectural trace.
            if (kill_q || mem_flush_i) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              if (dbus.dbus_err_i) err_q <= 1'b1;
              else if (!req_q.we)  rdata_q <= ext;
            end
          end else if (mem_flush_i) begin
            kill_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall_req_o = (state_q == IDLE && req_valid_i && aligned && !mem_flush_i) ||
                           (state_q == BUSY);
  assign rdata_o          = rdata_q;
  assign misaligned_o     = mis_q;
  assign bus_err_o        = err_q;
  assign dbus.dbus_addr_o = addr_q;
  assign dbus.dbus_dat_o  = dat_q;
  assign dbus.dbus_sel_o  = sel_q;
  assign dbus.dbus_we_o   = we_q;
  assign dbus.dbus_cyc_o  = cyc_q;
  assign dbus.dbus_stb_o  = cyc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a pipeline/responder driver queues expectations
// from a behavioural model, a negedge monitor pops and compares what the DUT shows.
module tb_mem_access_unit;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0, mem_flush_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        mem_stall_req_o, misaligned_o, bus_err_o;
  logic [31:0] rdata_o;

  always #5 clk_i = ~clk_i;

  mem_access_unit_if dbus();

  mem_access_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .mem_flush_i(mem_flush_i), .mem_stall_req_o(mem_stall_req_o),
    .rdata_o(rdata_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o), .dbus(dbus)
  );

  typedef enum {K_LOAD, K_STORE, K_ERR, K_FLUSH, K_MIS} kind_t;
  typedef struct { logic [31:0] addr; logic [31:0] dat; logic [3:0] sel; logic we; int gap; } bus_exp_t;
  typedef struct { kind_t kind; logic [31:0] rdata; int blen; } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0, passed = 0;
  logic [31:0] m_rdata = '0;
  int chain_gap = -1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic unexpected(input string n);
    checks++;
    $display("FAIL %s: event seen with no expectation queued", n);
  endtask

  // Reference model: plain arithmetic on sizes in bytes.
  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input int off, input logic [31:0] d);
    int nb;
    logic [31:0] v, mask;
    if (size == 2'd2) return d;
    nb   = 1 << size;
    v    = d >> (8 * off);
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] size, input int off);
    int nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdat(input logic [1:0] size, input logic [31:0] w);
    int nb;
    logic [31:0] r;
    nb = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) tick();
    if (n > 0) chain_gap = -1;
  endtask

  // resp: 0 ack, 1 err, 2 ack+err. flush_at: BUSY cycle index carrying flush, -1 none.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int waitc,
                        input int resp, input int flush_at, input logic [31:0] rdat);
    bus_exp_t b;
    rsp_exp_t r;
    int off;
    off = int'(addr[1:0]);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    if (size == 2'd3 || (off % (1 << size)) != 0) begin
      r.kind = K_MIS; r.rdata = m_rdata; r.blen = 0;
      rsp_q.push_back(r);
      tick();
      req_valid_i = 1'b0;
      chain_gap = -1;
      return;
    end
    b.addr = addr & ~32'h3; b.sel = m_sel(size, off); b.dat = m_wdat(size, wdata);
    b.we = we; b.gap = chain_gap;
    bus_q.push_back(b);
    if (flush_at >= 0 && flush_at <= waitc) r.kind = K_FLUSH;
    else if (resp != 0)                     r.kind = K_ERR;
    else if (we)                            r.kind = K_STORE;
    else begin
      r.kind  = K_LOAD;
      m_rdata = m_load(size, uns, off, rdat);
    end
    r.rdata = m_rdata; r.blen = waitc + 1;
    rsp_q.push_back(r);
    tick();
    for (int i = 0; i <= waitc; i++) begin
      mem_flush_i = (i == flush_at);
      if (i == waitc) begin
        dbus.dbus_dat_i = rdat;
        dbus.dbus_ack_i = (resp != 1);
        dbus.dbus_err_i = (resp != 0);
      end
      tick();
      mem_flush_i = 1'b0; dbus.dbus_ack_i = 1'b0; dbus.dbus_err_i = 1'b0;
      dbus.dbus_dat_i = $urandom;
    end
    if (r.kind == K_FLUSH) chain_gap = 1;
    else begin
      tick();
      chain_gap = 2;
    end
    req_valid_i = 1'b0;
  endtask

  // Monitor
  logic        prev_cyc = 1'b0, prev_stall = 1'b0, stall_ok, stable_ok;
  int          cyc_cnt = 0, cycle = 0, last_fall = -1000;
  bus_exp_t    cur_b;
  rsp_exp_t    cur_r;
  initial forever begin
    @(negedge clk_i);
    cycle++;
    if (!rst_ni) begin
      chk("rst_cyc",   32'(dbus.dbus_cyc_o), 0);
      chk("rst_stb",   32'(dbus.dbus_stb_o), 0);
      chk("rst_we",    32'(dbus.dbus_we_o), 0);
      chk("rst_sel",   32'(dbus.dbus_sel_o), 0);
      chk("rst_addr",  dbus.dbus_addr_o, 0);
      chk("rst_dat",   dbus.dbus_dat_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_mis",   32'(misaligned_o), 0);
      chk("rst_err",   32'(bus_err_o), 0);
      prev_cyc = 1'b0; prev_stall = 1'b0; cyc_cnt = 0;
      continue;
    end
    if (dbus.dbus_cyc_o && !prev_cyc) begin
      if (bus_q.size() == 0) unexpected("bus_issue");
      else begin
        cur_b = bus_q.pop_front();
        chk("issue_addr", dbus.dbus_addr_o, cur_b.addr);
        chk("issue_sel",  32'(dbus.dbus_sel_o), 32'(cur_b.sel));
        chk("issue_we",   32'(dbus.dbus_we_o), 32'(cur_b.we));
        if (cur_b.we) chk("issue_dat", dbus.dbus_dat_o, cur_b.dat);
        chk("issue_stall", 32'(prev_stall), 1);
        if (cur_b.gap >= 0) chk("issue_gap", 32'(cycle - last_fall), 32'(cur_b.gap));
      end
      cyc_cnt = 0; stall_ok = 1'b1; stable_ok = 1'b1;
    end
    if (dbus.dbus_cyc_o) begin
      cyc_cnt++;
      if (!mem_stall_req_o || !dbus.dbus_stb_o) stall_ok = 1'b0;
      if (dbus.dbus_addr_o !== cur_b.addr || dbus.dbus_sel_o !== cur_b.sel ||
          dbus.dbus_we_o !== cur_b.we || (cur_b.we && dbus.dbus_dat_o !== cur_b.dat))
        stable_ok = 1'b0;
    end
    if (!dbus.dbus_cyc_o && prev_cyc) begin
      last_fall = cycle;
      if (rsp_q.size() == 0 || rsp_q[0].kind == K_MIS) unexpected("bus_complete");
      else begin
        cur_r = rsp_q.pop_front();
        chk("busy_len",   32'(cyc_cnt), 32'(cur_r.blen));
        chk("busy_stall", 32'(stall_ok), 1);
        chk("busy_stable", 32'(stable_ok), 1);
        chk("end_stb",    32'(dbus.dbus_stb_o), 0);
        chk("end_rdata",  rdata_o, cur_r.rdata);
        chk("end_buserr", 32'(bus_err_o), 32'(cur_r.kind == K_ERR));
        if (cur_r.kind != K_FLUSH) chk("done_stall", 32'(mem_stall_req_o), 0);
      end
    end else if (bus_err_o) unexpected("bus_err");
    if (misaligned_o) begin
      if (rsp_q.size() == 0 || rsp_q[0].kind != K_MIS) unexpected("misaligned");
      else begin
        cur_r = rsp_q.pop_front();
        chk("mis_cyc",   32'(dbus.dbus_cyc_o), 0);
        chk("mis_stall", 32'(prev_stall), 0);
        chk("mis_rdata", rdata_o, cur_r.rdata);
      end
    end
    prev_cyc   = dbus.dbus_cyc_o;
    prev_stall = mem_stall_req_o;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          w, rs, fl;
    dbus.dbus_dat_i = '0; dbus.dbus_ack_i = 1'b0; dbus.dbus_err_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    // Signed byte load right after reset release, then a back-to-back halfword store
    access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 2, 0, -1, 32'h80FF_FF12);
    access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1, 0, -1, 32'h0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 0, 0, -1, 32'h0);
    idle(1);
    // Flush during BUSY; the next access must issue straight from IDLE
    access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 3, 0, 0, 32'h1234_5678);
    access(1'b0, 2'd2, 1'b0, 32'h0000_4100, 32'h0, 0, 0, -1, 32'hCAFE_F00D);
    access(1'b0, 2'd1, 1'b1, 32'h0000_5000, 32'h0, 1, 1, -1, 32'hDEAD_BEEF);
    access(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 0, 0, -1, 32'h0BAD_F00D);
    access(1'b1, 2'd2, 1'b0, 32'h0000_6004, 32'hA5A5_5A5A, 0, 0, -1, 32'h0);
    access(1'b0, 2'd0, 1'b1, 32'h0000_6001, 32'h0, 0, 2, -1, 32'h0000_FF00);
    idle(1);
    // Reset in the middle of a bus cycle, then a stray ack
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h0000_7000;
    bus_q.push_back('{addr: 32'h0000_7000, dat: 32'h0, sel: 4'hF, we: 1'b0, gap: -1});
    tick(); tick();
    rst_ni = 1'b0; req_valid_i = 1'b0; m_rdata = '0;
    tick(); tick();
    rst_ni = 1'b1; chain_gap = -1;
    dbus.dbus_ack_i = 1'b1; dbus.dbus_dat_i = 32'h7777_7777;
    tick();
    dbus.dbus_ack_i = 1'b0;
    idle(2);
    access(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 0, 1, -1, 32'h1111_1111);
    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 2) != 0) sz = 2'd2;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      w  = $urandom_range(0, 3);
      rs = $urandom_range(0, 9);
      rs = (rs < 7) ? 0 : (rs < 9) ? 1 : 2;
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
      access(1'($urandom), sz, 1'($urandom), a, $urandom, w, rs, fl, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("bus_q_drained", 32'(bus_q.size()), 0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
